// File: rtl/prng_pkg.sv
// Shared types and constants for the PRNG arbiter slice.
package prng_pkg;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RST_GEN = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } arb_state_t;

    // Width of the generator seed and result.
    localparam int PRNG_W = 8;

    // Cycles from request sampling to ack with a healthy generator.
    localparam int GEN_LATENCY = 14;

endpackage

// File: rtl/prng_rr_picker.sv
// Combinational round-robin picker: first set request bit scanning from ptr upward, modulo N_REQ.
module prng_rr_picker #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] winner_o
);

    localparam int SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] sum;

    // Scan offsets from highest to lowest so the smallest offset from ptr wins.
    always_comb begin
        found_o  = |req_i;
        winner_o = '0;
        sum      = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            sum = {1'b0, ptr_i} + SUM_W'(i);
            if (sum >= SUM_W'(N_REQ)) begin
                sum = sum - SUM_W'(N_REQ);
            end
            if (req_i[sum[IDX_W-1:0]]) begin
                winner_o = sum[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/prng_arbiter.sv
// Round-robin arbiter that shares one PRNG generator among N_REQ requesters.
//
// Handshake: a requester raises req[i] with its seed/select and keeps it up
// until ack[i]. ack[i] is a single-cycle pulse; rsp_data/rsp_err are valid only
// in that cycle. Seed and select are latched at grant, so later changes on
// req_seed/req_sel (or dropping req) do not affect the transaction in flight.
module prng_arbiter
    import prng_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 31,
    parameter int TO_W    = 5
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [PRNG_W*N_REQ-1:0]   req_seed,
    input  logic [N_REQ-1:0]          req_sel,
    output logic [N_REQ-1:0]          ack,
    output logic [PRNG_W-1:0]         rsp_data,
    output logic                      rsp_err,
    output logic                      busy,
    output logic                      gen_reset,
    output logic                      gen_en,
    output logic                      gen_sel,
    output logic [PRNG_W-1:0]         gen_seed,
    input  logic                      gen_valid,
    input  logic [PRNG_W-1:0]         gen_rand
);

    localparam int IDX_W = $clog2(N_REQ);

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  win_q, win_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic [PRNG_W-1:0] seed_q, seed_d;
    logic              sel_q, sel_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic [PRNG_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              en_q, en_d;

    logic              pick_found;
    logic [IDX_W-1:0]  pick_winner;

    prng_rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .found_o  (pick_found),
        .winner_o (pick_winner)
    );

    // Next-state, latch and response logic for the grant/restart/wait/deliver sequence.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        seed_d  = seed_q;
        sel_d   = sel_q;
        ack_d   = '0;
        data_d  = data_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    win_d = pick_winner;
                    for (int i = 0; i < N_REQ; i++) begin
                        if (pick_winner == IDX_W'(i)) begin
                            seed_d = req_seed[i*PRNG_W +: PRNG_W];
                            sel_d  = req_sel[i];
                        end
                    end
                    state_d = RST_GEN;
                end
            end
            RST_GEN: begin
                // The generator's done state is sticky, so every grant restarts it.
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A valid result wins over a coincident timeout.
                if (gen_valid) begin
                    data_d  = gen_rand;
                    err_d   = 1'b0;
                    ack_d   = {{(N_REQ-1){1'b0}}, 1'b1} << win_q;
                    state_d = DELIVER;
                end else if (cnt_q == TO_W'(TIMEOUT)) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    ack_d   = {{(N_REQ-1){1'b0}}, 1'b1} << win_q;
                    state_d = DELIVER;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            DELIVER: begin
                if (win_q == IDX_W'(N_REQ - 1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = win_q + IDX_W'(1);
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        en_d   = (state_d == WAIT);
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any transaction without ack or pointer update.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            cnt_q   <= '0;
            seed_q  <= '0;
            sel_q   <= 1'b0;
            ack_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            seed_q  <= seed_d;
            sel_q   <= sel_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            en_q    <= en_d;
        end
    end

    // The generator is held in reset whenever the arbiter is, hence the combinational term.
    assign gen_reset = reset | (state_q == RST_GEN);
    assign gen_en    = en_q;
    assign gen_sel   = sel_q;
    assign gen_seed  = seed_q;
    assign ack       = ack_q;
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_prng_arbiter.sv
// Bench for prng_arbiter: generator model, transaction-level reference model, directed and random stimulus.
module tb_prng_arbiter;
    import prng_pkg::*;

    localparam int N  = 4;
    localparam int TO = 31;

    logic             clock     = 1'b0;
    logic             reset     = 1'b1;
    logic [N-1:0]     req       = '0;
    logic [8*N-1:0]   req_seed  = '0;
    logic [N-1:0]     req_sel   = '0;
    logic [N-1:0]     ack;
    logic [7:0]       rsp_data;
    logic             rsp_err;
    logic             busy;
    logic             gen_reset;
    logic             gen_en;
    logic             gen_sel;
    logic [7:0]       gen_seed;
    logic             gen_valid = 1'b0;
    logic [7:0]       gen_rand  = '0;

    prng_arbiter #(
        .N_REQ   (N),
        .TIMEOUT (TO),
        .TO_W    (5)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .req_seed  (req_seed),
        .req_sel   (req_sel),
        .ack       (ack),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .gen_reset (gen_reset),
        .gen_en    (gen_en),
        .gen_sel   (gen_sel),
        .gen_seed  (gen_seed),
        .gen_valid (gen_valid),
        .gen_rand  (gen_rand)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference generator: 8 LFSR steps then a nibble-swap/xor S-box.
    function automatic logic [7:0] prng_ref(input logic [7:0] seed, input logic sel);
        logic [7:0] s;
        s = seed;
        for (int k = 0; k < 8; k++) begin
            if (!sel) s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
            else      s = s[7] ? ({s[6:0], 1'b0} ^ 8'h1D) : {s[6:0], 1'b0};
        end
        return {s[3:0], s[7:4]} ^ 8'h63;
    endfunction

    // ---------------- generator model ----------------
    // Valid appears after g_delay enabled cycles since the last generator reset (12 = healthy).
    int g_cnt   = 0;
    int g_delay = GEN_LATENCY - 2;

    always @(negedge clock) begin
        if (gen_reset) begin
            g_cnt     = 0;
            gen_valid = 1'b0;
        end else if (gen_en) begin
            g_cnt++;
            if (g_cnt == g_delay) begin
                gen_valid = 1'b1;
                gen_rand  = prng_ref(gen_seed, gen_sel);
            end
        end
        if (!gen_valid) gen_rand = 8'($urandom);
    end

    // ---------------- reference model (transaction level) ----------------
    // m_t counts cycles since the grant cycle; waiting lasts until valid or m_t-2 reaches TO.
    bit         m_known   = 0;
    bit         m_idle    = 1;
    int         m_t       = 0;
    int         m_win     = 0;
    int         m_ptr     = 0;
    bit         m_deliver = 0;
    logic [7:0] m_seed    = '0;
    logic       m_sel     = 1'b0;
    logic [7:0] m_data    = '0;
    logic       m_err     = 1'b0;

    always @(posedge clock) begin
        bit found;
        int c;
        cyc++;
        if (reset) begin
            m_known = 1; m_idle = 1; m_t = 0; m_ptr = 0; m_deliver = 0;
            m_seed = '0; m_sel = 1'b0; m_data = '0; m_err = 1'b0;
        end else if (m_idle) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (!found && req[c]) begin
                    found = 1;
                    m_win = c;
                end
            end
            if (found) begin
                m_seed = req_seed[m_win*8 +: 8];
                m_sel  = req_sel[m_win];
                m_idle = 0;
                m_t    = 1;
            end
        end else if (m_deliver) begin
            m_deliver = 0;
            m_idle    = 1;
            m_ptr     = (m_win + 1) % N;
        end else begin
            if (m_t >= 2) begin
                if (gen_valid) begin
                    m_data = gen_rand; m_err = 1'b0; m_deliver = 1;
                end else if (m_t - 2 == TO) begin
                    m_data = 8'h00; m_err = 1'b1; m_deliver = 1;
                end
            end
            m_t++;
        end
    end

    // ---------------- scoreboard / compare ----------------
    logic [1:0] exp_q[$];
    int         acks          = 0;
    int         last_ack_idx  = -1;
    int         last_ack_cyc  = 0;
    int         last_grst_cyc = 0;
    logic [7:0] last_ack_data = '0;
    logic [7:0] last_ack_seed = '0;
    logic       last_ack_err  = 1'b0;
    logic       last_ack_sel  = 1'b0;

    always @(negedge clock) begin
        logic [N-1:0] exp_ack;
        if (m_known) begin
            exp_ack = m_deliver ? (N'(1) << m_win) : '0;
            check("gen_reset", 32'(gen_reset), 32'(reset || (!m_idle && m_t == 1)));
            check("busy",      32'(busy),      32'(!m_idle));
            check("gen_en",    32'(gen_en),    32'(!m_idle && m_t >= 2 && !m_deliver));
            check("ack",       32'(ack),       32'(exp_ack));
            check("gen_seed",  32'(gen_seed),  32'(m_seed));
            check("gen_sel",   32'(gen_sel),   32'(m_sel));
            if (m_deliver) begin
                check("rsp_data", 32'(rsp_data), 32'(m_data));
                check("rsp_err",  32'(rsp_err),  32'(m_err));
            end
        end
        if (gen_reset && !reset) last_grst_cyc = cyc;
        if (ack != '0) begin
            acks++;
            for (int k = 0; k < N; k++) if (ack[k]) last_ack_idx = k;
            last_ack_cyc  = cyc;
            last_ack_data = rsp_data;
            last_ack_err  = rsp_err;
            last_ack_seed = gen_seed;
            last_ack_sel  = gen_sel;
            if (exp_q.size() > 0) check("ack_order", 32'(last_ack_idx), 32'(exp_q.pop_front()));
        end
    end

    // ---------------- driver tasks ----------------
    logic [N-1:0] hold_mask = '0;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    // Wait for the next ack; a requester not in hold_mask drops req after its ack.
    task automatic wait_ack(input int budget, output int idx, output int c);
        int start;
        bit seen;
        start = acks; seen = 0; idx = -1; c = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick(1);
            if (acks != start) seen = 1;
        end
        check("ack_within_budget", 32'(seen), 32'd1);
        if (seen) begin
            idx = last_ack_idx;
            c   = last_ack_cyc;
            if (!hold_mask[idx]) req[idx] = 1'b0;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int idx, c, c0, prev, a0, rst_left, acks0;
        logic [7:0] s;

        do_reset();

        // 1: single request, Fibonacci seed 0x01.
        req_seed[7:0] = 8'h01; req_sel[0] = 1'b0;
        req = 4'b0001; c0 = cyc;
        wait_ack(40, idx, c);
        check("t1_idx", 32'(idx), 32'd0);
        check("t1_latency", 32'(c - c0), 32'(GEN_LATENCY));
        check("t1_grst_cycle", 32'(last_grst_cyc - c0), 32'd1);
        check("t1_seed", 32'(last_ack_seed), 32'h01);
        check("t1_data", 32'(last_ack_data), 32'hA2);
        check("t1_err", 32'(last_ack_err), 32'd0);

        // 2: all requesters at once from reset.
        do_reset();
        req_seed = {8'h44, 8'h33, 8'h22, 8'h11};
        req_sel  = 4'b1010;
        exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2); exp_q.push_back(2'd3);
        req = 4'b1111; prev = cyc - 1;
        for (int k = 0; k < 4; k++) begin
            wait_ack(40, idx, c);
            check("t2_spacing", 32'(c - prev), 32'(GEN_LATENCY + 1));
            s = 8'h11 * 8'(k + 1);
            check("t2_seed", 32'(last_ack_seed), 32'(s));
            prev = c;
        end

        // 3: fairness with 0 and 2 held, then 1 joins.
        hold_mask = 4'b0101;
        exp_q.push_back(2'd0); exp_q.push_back(2'd2); exp_q.push_back(2'd0); exp_q.push_back(2'd2);
        req = 4'b0101;
        for (int k = 0; k < 4; k++) wait_ack(40, idx, c);
        exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
        req[1] = 1'b1;
        for (int k = 0; k < 3; k++) wait_ack(40, idx, c);
        check("t3_last_idx", 32'(idx), 32'd2);
        hold_mask = '0; req = '0;

        // 4: timeout with dead generator, then recovery, then boundary cases.
        g_delay = 1000;
        req_seed[31:24] = 8'h9C;
        req = 4'b1000; c0 = cyc;
        wait_ack(60, idx, c);
        check("t4_idx", 32'(idx), 32'd3);
        check("t4_to_cycle", 32'(c - c0), 32'(TO + 3));
        check("t4_to_err", 32'(last_ack_err), 32'd1);
        check("t4_to_data", 32'(last_ack_data), 32'h00);
        g_delay = GEN_LATENCY - 2;
        req_seed[7:0] = 8'h01; req_sel[0] = 1'b0;
        req = 4'b0001; c0 = cyc;
        wait_ack(40, idx, c);
        check("t4_recover_latency", 32'(c - c0), 32'(GEN_LATENCY));
        check("t4_recover_data", 32'(last_ack_data), 32'hA2);
        check("t4_recover_err", 32'(last_ack_err), 32'd0);
        // valid on the timeout cycle: valid wins.
        g_delay = TO + 1;
        req_seed[7:0] = 8'h37; req_sel[0] = 1'b1;
        req = 4'b0001; c0 = cyc;
        wait_ack(60, idx, c);
        check("t4_tie_cycle", 32'(c - c0), 32'(TO + 3));
        check("t4_tie_err", 32'(last_ack_err), 32'd0);
        check("t4_tie_data", 32'(last_ack_data), 32'(prng_ref(8'h37, 1'b1)));
        // valid one cycle too late: timeout.
        g_delay = TO + 2;
        req = 4'b0001; c0 = cyc;
        wait_ack(60, idx, c);
        check("t4_late_cycle", 32'(c - c0), 32'(TO + 3));
        check("t4_late_err", 32'(last_ack_err), 32'd1);
        g_delay = GEN_LATENCY - 2;

        // 5: reset during WAIT.
        acks0 = acks;
        req = 4'b0100; c0 = cyc;
        tick(8);
        reset = 1'b1; req = '0;
        tick(2);
        check("t5_ack", 32'(ack), 32'd0);
        check("t5_rsp_data", 32'(rsp_data), 32'h00);
        check("t5_rsp_err", 32'(rsp_err), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_gen_en", 32'(gen_en), 32'd0);
        check("t5_gen_sel", 32'(gen_sel), 32'd0);
        check("t5_gen_seed", 32'(gen_seed), 32'h00);
        check("t5_gen_reset", 32'(gen_reset), 32'd1);
        check("t5_no_ack", 32'(acks), 32'(acks0));
        reset = 1'b0;
        req = 4'b1010;
        wait_ack(40, idx, c);
        check("t5_ptr_zero_grant", 32'(idx), 32'd1);
        req = '0;
        tick(1);

        // 6: drop request and change seed mid-service.
        req_seed[15:8] = 8'h5A; req_sel[1] = 1'b1;
        req = 4'b0010; c0 = cyc;
        tick(5);
        req[1] = 1'b0; req_seed[15:8] = 8'hFF; req_sel[1] = 1'b0;
        wait_ack(40, idx, c);
        check("t6_idx", 32'(idx), 32'd1);
        check("t6_latency", 32'(c - c0), 32'(GEN_LATENCY));
        check("t6_seed", 32'(last_ack_seed), 32'h5A);
        check("t6_sel", 32'(last_ack_sel), 32'd1);
        check("t6_data", 32'(last_ack_data), 32'(prng_ref(8'h5A, 1'b1)));

        // Random phase: every cycle is checked against the reference model.
        a0 = acks; rst_left = 0;
        for (int i = 0; i < 4000; i++) begin
            tick(1);
            req_seed = {$urandom, $urandom};
            req_sel  = N'($urandom);
            if ($urandom_range(0, 7) == 0) req = N'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 3))
                    0:       g_delay = 1000;
                    1:       g_delay = $urandom_range(1, 40);
                    default: g_delay = GEN_LATENCY - 2;
                endcase
            end
            if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) reset = 1'b0;
            end else if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                rst_left = $urandom_range(1, 3);
            end
        end
        reset = 1'b0; req = '0;
        tick(60);
        check("rand_acks_seen", 32'(acks > a0 + 50), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prng_arbiter.md
# prng_arbiter

Round-robin arbiter and sequencer that shares one `prng_chip` generator among `N_REQ` requesters. It latches the winning requester's seed and LFSR select, then restarts the generator with a reset pulse, because the generator's done state is sticky. It holds the generator enable until `valid`, captures the S-box output and returns it with a one-cycle acknowledge. A watchdog bounds each transaction.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 31: maximum WAIT cycles before the error return.
- `TO_W`, default 5: timeout counter width; must satisfy `TIMEOUT < 2**TO_W`.

Ports:
- `clock`  in  1: clock.
- `reset`  in  1: synchronous, active-high.
- `req`  in  N_REQ: level request; held by the requester until its `ack`.
- `req_seed`  in  8*N_REQ: seed of requester i in bits [8i+7:8i].
- `req_sel`  in  N_REQ: LFSR choice of requester i (0 Fibonacci, 1 Galois).
- `ack`  out  N_REQ: one-hot, one-cycle pulse to the served requester.
- `rsp_data`  out  8: result byte; valid only while `ack` is nonzero.
- `rsp_err`  out  1: timeout flag; valid only while `ack` is nonzero.
- `busy`  out  1: high in every state except IDLE.
- `gen_reset`  out  1: reset to the generator.
- `gen_en`  out  1: generator enable.
- `gen_sel`  out  1: generator LFSR select.
- `gen_seed`  out  8: generator seed.
- `gen_valid`  in  1: generator valid.
- `gen_rand`  in  8: generator result.

## Operation
- **States:** IDLE, RST_GEN, WAIT, DELIVER.
- **IDLE**
  - If any `req` bit is set, pick a winner by round-robin from pointer `ptr`: the first set bit scanning `ptr`, `ptr+1`, … modulo `N_REQ`.
  - Latch the winner index, its seed into `gen_seed` and its select into `gen_sel`, then go to RST_GEN.
  - Otherwise stay in IDLE.
- **RST_GEN:** `gen_reset`=1 for exactly one cycle; clear the timeout counter; go to WAIT.
- **WAIT**
  - `gen_en`=1.
  - If `gen_valid`: capture `gen_rand` into `rsp_data`, set `rsp_err`=0, go to DELIVER.
  - Else if counter == `TIMEOUT`: set `rsp_data`=0x00, `rsp_err`=1, go to DELIVER.
  - Else increment the counter.
- **DELIVER:** `ack[winner]`=1 for one cycle; `ptr` = (winner+1) mod `N_REQ`; go to IDLE.
- **Latched fields:** `gen_seed` and `gen_sel` stay constant from IDLE exit until the next IDLE exit. Changes on `req_seed` or `req_sel` during service are ignored.
- **Dropped request:** a requester that drops `req` mid-service still gets its `ack`. The transaction always completes.
- **DELIVER→IDLE gap:** a requester still holding `req` after its `ack` is eligible again, but loses to any other pending requester under the updated `ptr`.
- **Reset values:**
  - State IDLE, `ptr`=0, counter 0.
  - `ack`=0, `rsp_data`=0x00, `rsp_err`=0, `busy`=0.
  - `gen_en`=0, `gen_sel`=0, `gen_seed`=0x00.
  - `gen_reset` = `reset` OR (state == RST_GEN), so the generator also resets whenever the arbiter resets.
- **Reset mid-transaction:** abort with no `ack` and no pointer update.

## Timing
All cycles are counted from cycle 0, the IDLE cycle in which `req` is sampled.
- Cycle 1: `gen_reset`=1.
- Cycle 2: WAIT begins; `gen_en`=1.
- With a healthy generator:
  - Load on cycle 3.
  - Eight shifts plus count compare on cycles 4–12.
  - `gen_valid` on cycle 13.
  - `ack` on cycle 14.
  - Service time 14 cycles; back-to-back grants every 15 cycles because IDLE takes one cycle.
- Timeout: the counter reaches `TIMEOUT` on cycle 2+`TIMEOUT` (33 by default); `ack` with error on cycle 34.
- If `gen_valid` and the timeout coincide, `gen_valid` wins.
- All outputs are registered except `gen_reset`, which contains the combinational `reset` term.

## Structure
- **Package `prng_pkg`:**
  - state enum `arb_state_t` {IDLE, RST_GEN, WAIT, DELIVER}.
  - constant `PRNG_W`=8.
  - constant `GEN_LATENCY`=14.
- **Sub-module `prng_rr_picker`:** combinational, inputs `req` and `ptr`; outputs `found` and `winner` index. It is kept separate so it can be verified exhaustively.
- **Top-level contents:** FSM, latches, timeout counter.

## Test plan
1. **Single request.** After reset, `req`=0001, seed 0x01, sel 0. Expect `gen_reset` on cycle 1, `gen_seed`=0x01, `ack`=0001 on cycle 14, `rsp_err`=0, and `rsp_data` equal to the reference model's Fibonacci+S-box byte.
2. **All requesters at once.** `req`=1111 from reset, each held until its own `ack`. Expect acks in order 0,1,2,3, 15 cycles apart, with each `gen_seed` matching its requester.
3. **Fairness.** Hold `req[0]` and `req[2]` continuously. Expect grants to alternate 0,2,0,2; `req[1]` raised later is served within one rotation.
4. **Timeout.** Tie `gen_valid`=0. Expect `ack` on cycle 34 with `rsp_err`=1 and `rsp_data`=0x00, then the next request proceeds normally.
5. **Reset in WAIT.** Assert `reset` on cycle 8. Expect all outputs at reset values, `gen_reset`=1 during reset, no `ack`, and `ptr`=0 on the next grant.
6. **Changed inputs mid-service.** Drop `req[1]` and change `req_seed[1]` to 0xFF on cycle 5. Expect `ack[1]` still on cycle 14, and `gen_seed` unchanged at the value latched on cycle 0.
